p2s_ctrl: RTL

//  Control stage directly upstream of the 8:1 serializer mux (mux_p2s) in the p2s path.

---
 rtl/p2s_ctrl_pkg.sv | 18 +
 rtl/p2s_bit_cnt.sv | 29 ++
 rtl/p2s_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/p2s_ctrl_pkg.sv
// Shared constants and state encoding for the p2s control stage and its bit counter.
package p2s_ctrl_pkg;

    localparam int P2S_WIDTH = 8;
    localparam int P2S_SEL_W = 3;
    localparam logic [P2S_SEL_W-1:0] P2S_LAST_SEL = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } p2s_state_t;

    // True when the counter sits on the last bit of a byte.
    function automatic logic is_last_sel(input logic [P2S_SEL_W-1:0] sel);
        return sel == P2S_LAST_SEL;
    endfunction

endpackage

// File: rtl/p2s_bit_cnt.sv
// Serializer bit index counter: clear has priority, then increment unless held.
module p2s_bit_cnt
    import p2s_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 i_inc,
    input  logic                 i_clr,
    input  logic                 i_hold,
    output logic [P2S_SEL_W-1:0] o_cnt,
    output logic                 o_last
);

    logic [P2S_SEL_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_hold) begin
            r_cnt <= r_cnt + P2S_SEL_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = is_last_sel(r_cnt);

endmodule

// File: rtl/p2s_ctrl.sv
// Control stage ahead of the 8:1 serializer mux: latches a byte per handshake and walks
// the mux select LSB first, chaining the next byte onto the last bit without a gap.
module p2s_ctrl
    import p2s_ctrl_pkg::*;
#(
    parameter int WIDTH = P2S_WIDTH,
    parameter int SEL_W = P2S_SEL_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             ser_en,
    output logic [WIDTH-1:0] hold_data,
    output logic [SEL_W-1:0] sel,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    p2s_state_t       r_state;
    logic [WIDTH-1:0] r_hold_data;

    logic             w_is_shift;
    logic             w_last;
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic             w_cnt_hold;
    logic [SEL_W-1:0] w_sel;

    // Anything that is not SHIFT behaves as IDLE.
    assign w_is_shift = (r_state == ST_SHIFT);

    // Handshake: a transfer occurs at a rising edge when in_valid & in_ready are both high.
    // in_data must stay stable while in_valid=1 and in_ready=0. in_ready is held low in reset.
    assign w_in_ready = reset_L & (~w_is_shift | (w_last & ser_en));
    assign w_xfer     = in_valid & w_in_ready;

    // Counter advances only on enabled cycles; the 7 -> 0 wrap is an explicit clear.
    assign w_cnt_inc  = w_is_shift & ser_en & ~w_last;
    assign w_cnt_clr  = ~w_is_shift | (ser_en & w_last);
    assign w_cnt_hold = ~ser_en;

    p2s_bit_cnt u_bit_cnt (
        .clk     (clk),
        .reset_L (reset_L),
        .i_inc   (w_cnt_inc),
        .i_clr   (w_cnt_clr),
        .i_hold  (w_cnt_hold),
        .o_cnt   (w_sel),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= ST_IDLE;
            r_hold_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_hold_data <= in_data;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_en && w_last) begin
                        if (w_xfer) begin
                            r_hold_data <= in_data;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign hold_data   = r_hold_data;
    assign sel         = w_sel;
    assign ser_valid   = w_is_shift & ser_en;
    assign frame_start = w_is_shift & ser_en & (w_sel == '0);
    assign busy        = w_is_shift;

endmodule
